// File: rtl/cascade_add_scheduler.sv
// cascade_add_scheduler: round-robin shared two-pass three-operand adder with tagged response
module adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] s
);
  assign s = a + b;
endmodule

module cascade_add_scheduler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  req0_valid_in,
  output logic                  req0_ready_out,
  input  logic [DATA_WIDTH-1:0] req0_a_in,
  input  logic [DATA_WIDTH-1:0] req0_b_in,
  input  logic [DATA_WIDTH-1:0] req0_c_in,
  input  logic                  req1_valid_in,
  output logic                  req1_ready_out,
  input  logic [DATA_WIDTH-1:0] req1_a_in,
  input  logic [DATA_WIDTH-1:0] req1_b_in,
  input  logic [DATA_WIDTH-1:0] req1_c_in,
  output logic                  rsp_valid_out,
  input  logic                  rsp_ready_in,
  output logic [DATA_WIDTH-1:0] rsp_sum_out,
  output logic                  rsp_id_out,
  output logic                  busy_out
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
  state_t state, state_nx;
  logic rr_ptr, id, rsp_valid, grant0, grant1, accept;
  logic [DATA_WIDTH-1:0] op_a, op_b, op_c, partial, sum, add_x, add_y, add_s;
  assign grant0 = req0_valid_in & (~req1_valid_in | ~rr_ptr);
  assign grant1 = req1_valid_in & (~req0_valid_in | rr_ptr);
  assign req0_ready_out = reset_n_in & (state == IDLE) & grant0;
  assign req1_ready_out = reset_n_in & (state == IDLE) & grant1;
  assign accept = req0_ready_out | req1_ready_out;
  assign add_x = (state == PASS2) ? partial : op_a;
  assign add_y = (state == PASS2) ? op_c : op_b;
  assign rsp_valid_out = rsp_valid;
  assign rsp_sum_out = sum;
  assign rsp_id_out = id;
  assign busy_out = state != IDLE;
  adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (.a(add_x), .b(add_y), .s(add_s));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? PASS1 : IDLE;
      PASS1:   state_nx = PASS2;
      PASS2:   state_nx = RESP;
      RESP:    state_nx = rsp_ready_in ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rr_ptr    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      partial   <= '0;
      sum       <= '0;
      id        <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= grant1 ? req1_a_in : req0_a_in;
        op_b   <= grant1 ? req1_b_in : req0_b_in;
        op_c   <= grant1 ? req1_c_in : req0_c_in;
        id     <= grant1;
        rr_ptr <= ~grant1;
      end
      if (state == PASS1) partial <= add_s;
      if (state == PASS2) begin
        sum       <= add_s;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready_in) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cascade_add_scheduler.sv
// tb_cascade_add_scheduler: random and directed stimulus checked against a transaction-level model
module tb_cascade_add_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v0 = 0, v1 = 0, rsp_ready = 1;
  logic [31:0] a0 = 0, b0 = 0, c0 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic r0, r1, rsp_valid, rsp_id, busy;
  logic [31:0] rsp_sum;
  int vectors = 0, miscompares = 0, cyc = 0;
  bit m_busy, m_rr, m_id;
  int m_wait;
  logic [31:0] m_sum;
  int log_cyc[$];
  bit log_id[$];

  cascade_add_scheduler dut (
    .clock_in(clk), .reset_n_in(rst_n),
    .req0_valid_in(v0), .req0_ready_out(r0), .req0_a_in(a0), .req0_b_in(b0), .req0_c_in(c0),
    .req1_valid_in(v1), .req1_ready_out(r1), .req1_a_in(a1), .req1_b_in(b1), .req1_c_in(c1),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_sum_out(rsp_sum),
    .rsp_id_out(rsp_id), .busy_out(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit winner();
    return (v0 && v1) ? m_rr : v1;
  endfunction

  // Transaction model: one request in flight, result visible two edges after acceptance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_rr = 0; m_id = 0; m_sum = 0;
    end else if (!m_busy) begin
      if (v0 || v1) begin
        m_id = winner();
        m_sum = m_id ? a1 + b1 + c1 : a0 + b0 + c0;
        m_rr = !m_id;
        m_busy = 1;
        m_wait = 2;
      end
    end else if (m_wait > 0) m_wait--;
    else if (rsp_ready) m_busy = 0;
  end

  always @(negedge clk) begin
    bit any;
    any = v0 || v1;
    chk("ready0", {31'b0, r0}, {31'b0, rst_n && !m_busy && any && winner() == 0});
    chk("ready1", {31'b0, r1}, {31'b0, rst_n && !m_busy && any && winner() == 1});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_busy && m_wait == 0});
    if (m_busy && m_wait == 0) begin
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
    end
    if (r0 || r1) begin
      log_cyc.push_back(cyc);
      log_id.push_back(r1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      if (!busy) return;
      step();
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_one(input bit id, input logic [31:0] a, b, c, input logic [31:0] exp);
    wait_idle();
    rsp_ready = 1;
    if (id) begin a1 = a; b1 = b; c1 = c; v1 = 1; end
    else begin a0 = a; b0 = b; c0 = c; v0 = 1; end
    step();
    chk("accepted_busy", {31'b0, busy}, 32'd1);
    v0 = 0; v1 = 0;
    a0 = 32'h10; b0 = $urandom; c0 = $urandom;
    a1 = 32'h10; b1 = $urandom; c1 = $urandom;
    step();
    chk("latency_t1_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    chk("latency_t2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("direct_sum", rsp_sum, exp);
    chk("direct_id", {31'b0, rsp_id}, {31'b0, id});
    chk("model_sum", m_sum, exp);
  endtask

  initial begin
    logic [31:0] hs;
    bit hid, seen;
    repeat (3) step();
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", rsp_sum, 32'd0);
    chk("rst_id", {31'b0, rsp_id}, 32'd0);
    @(negedge clk); #1 rst_n = 1;
    step();
    run_one(0, 32'd1, 32'd2, 32'd3, 32'd6);
    run_one(1, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd5);
    // Contention: rr pointer is 0 here, so grants must run 0,1,0,1...
    wait_idle();
    log_cyc.delete(); log_id.delete();
    v0 = 1; v1 = 1; rsp_ready = 1;
    repeat (17) begin
      a0 = $urandom; b0 = $urandom; c0 = $urandom;
      a1 = $urandom; b1 = $urandom; c1 = $urandom;
      step();
    end
    v0 = 0; v1 = 0;
    chk("cont_count_ge4", {31'b0, log_id.size() >= 4}, 32'd1);
    for (int i = 0; i < log_id.size(); i++) begin
      chk("cont_id", {31'b0, log_id[i]}, i % 2);
      if (i > 0) chk("cont_interval", log_cyc[i] - log_cyc[i-1], 32'd4);
    end
    run_one(0, 32'd7, 32'd0, 32'd0, 32'd7);
    // Backpressure
    wait_idle();
    v0 = 1; v1 = 1; rsp_ready = 0;
    a0 = $urandom; b0 = $urandom; c0 = $urandom;
    a1 = $urandom; b1 = $urandom; c1 = $urandom;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = rsp_valid;
    end
    chk("bp_seen_valid", {31'b0, seen}, 32'd1);
    hs = rsp_sum; hid = rsp_id;
    repeat (5) begin
      step();
      chk("bp_sum_hold", rsp_sum, hs);
      chk("bp_id_hold", {31'b0, rsp_id}, {31'b0, hid});
      chk("bp_ready0", {31'b0, r0}, 32'd0);
      chk("bp_ready1", {31'b0, r1}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
    end
    rsp_ready = 1;
    step();
    chk("bp_release_idle", {31'b0, busy}, 32'd0);
    v0 = 0; v1 = 0;
    // Reset in the middle of PASS1
    wait_idle();
    v0 = 1; a0 = $urandom; b0 = $urandom; c0 = $urandom;
    step();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_ready0", {31'b0, r0}, 32'd0);
    chk("async_rst_ready1", {31'b0, r1}, 32'd0);
    v0 = 0;
    @(negedge clk); #1 rst_n = 1;
    repeat (6) step();
    // Random traffic
    repeat (400) begin
      v0 = $urandom_range(0, 1); v1 = $urandom_range(0, 1);
      a0 = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
      b0 = $urandom; c0 = $urandom;
      a1 = $urandom; b1 = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
      c1 = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    v0 = 0; v1 = 0; rsp_ready = 1;
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
